// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one unified memory port between the instruction-fetch requester
// (I) and the data-access requester (D) of the microcoded Y86 core. Each
// granted transaction is registered onto the memory port and held as a
// level request until mem_ack arrives. A watchdog aborts a hung
// transaction. mem_err records the abort and stays set until reset.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   i_req, i_addr       fetch request (level) and address
//   i_ready, i_rdata    one-cycle fetch-complete strobe and fetched word
//   d_req, d_we,        data request (level), write enable, address and
//   d_addr, d_wdata     write data
//   d_ready, d_rdata    one-cycle data-complete strobe and read data
//   mem_req, mem_we,    registered memory request, write enable, address
//   mem_addr, mem_wdata and write data
//   mem_rdata, mem_ack  memory read data and single-cycle completion pulse
//   mem_err             sticky watchdog-timeout flag
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_err
);

  // The watchdog counts 0 .. TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  logic             last_d;  // 1 = the most recent grant went to D
  logic [CNT_W-1:0] wdog;

  // Round-robin pick: D wins when it is the only requester, or when both
  // request and I was served last.
  function automatic logic grant_d(input logic ireq, input logic dreq,
                                   input logic last_was_d);
    return dreq && (!ireq || !last_was_d);
  endfunction

  function automatic logic grant_i(input logic ireq, input logic dreq,
                                   input logic last_was_d);
    return ireq && (!dreq || last_was_d);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_d    <= 1'b1;  // so I wins the first tie
      wdog      <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      // Ready strobes are one-cycle pulses; they are only set on the
      // transition into RESP.
      i_ready <= 1'b0;
      d_ready <= 1'b0;

      case (state)
        IDLE: begin
          wdog <= '0;
          if (grant_i(i_req, d_req, last_d)) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            last_d    <= 1'b0;
            state     <= BUSY_I;
          end else if (grant_d(i_req, d_req, last_d)) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            last_d    <= 1'b1;
            state     <= BUSY_D;
          end
        end

        BUSY_I, BUSY_D: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            wdog    <= '0;
            state   <= RESP;
            if (state == BUSY_I) begin
              i_rdata <= mem_rdata;
              i_ready <= 1'b1;
            end else begin
              // Writes leave the last read data untouched.
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
              d_ready <= 1'b1;
            end
          end else if (wdog == WDOG_LAST) begin
            // Abort: still strobe ready so the microsequencer cannot hang.
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            wdog    <= '0;
            state   <= RESP;
            if (state == BUSY_I) begin
              i_ready <= 1'b1;
            end else begin
              d_ready <= 1'b1;
            end
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end

        // Turnaround cycle: the ready strobe is visible here and requests
        // are not sampled, which gives the losing port its turn next.
        RESP: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          mem_err;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ready  (i_ready),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_i_ready",   i_ready,   0);
    check("rst_d_ready",   d_ready,   0);
    check("rst_mem_req",   mem_req,   0);
    check("rst_mem_we",    mem_we,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_rdata",   i_rdata,   0);
    check("rst_d_rdata",   d_rdata,   0);
    check("rst_mem_err",   mem_err,   0);

    // Fetch, ack two cycles after mem_req rises
    i_req  = 1'b1;
    i_addr = 64'h100;
    tick();
    check("f_mem_req",  mem_req,  1);
    check("f_mem_addr", mem_addr, 64'h100);
    check("f_mem_we",   mem_we,   0);
    check("f_no_ready", i_ready,  0);
    tick();
    check("f_req_held", mem_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = 64'h30F2_0000_0000_00AB;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    i_req     = 1'b0;
    check("f_i_ready", i_ready, 1);
    check("f_d_ready", d_ready, 0);
    check("f_req_drop", mem_req, 0);
    check("f_i_rdata", i_rdata, 64'h30F2_0000_0000_00AB);
    tick();
    check("f_ready_1cyc", i_ready, 0);
    check("f_rdata_hold", i_rdata, 64'h30F2_0000_0000_00AB);

    // Data write
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 64'h200;
    d_wdata = 64'hDEAD;
    tick();
    check("w_mem_req",   mem_req,   1);
    check("w_mem_we",    mem_we,    1);
    check("w_mem_addr",  mem_addr,  64'h200);
    check("w_mem_wdata", mem_wdata, 64'hDEAD);
    mem_ack   = 1'b1;
    mem_rdata = 64'h5555;
    tick();
    mem_ack = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    check("w_d_ready", d_ready, 1);
    check("w_i_ready", i_ready, 0);
    check("w_d_rdata", d_rdata, 0);
    tick();
    check("w_ready_1cyc", d_ready, 0);

    // Contention: last grant was D, so I, D, I, D
    i_req  = 1'b1;
    i_addr = 64'h300;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 64'h400;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_mem_req", mem_req, 1);
      check("rr_mem_addr", mem_addr, (k % 2 == 0) ? 64'h300 : 64'h400);
      mem_ack   = 1'b1;
      mem_rdata = 64'h1000 + 64'(k);
      tick();
      mem_ack = 1'b0;
      check("rr_i_ready", i_ready, (k % 2 == 0) ? 1 : 0);
      check("rr_d_ready", d_ready, (k % 2 == 0) ? 0 : 1);
      if (k % 2 == 0) check("rr_i_rdata", i_rdata, 64'h1000 + 64'(k));
      else            check("rr_d_rdata", d_rdata, 64'h1000 + 64'(k));
      tick();
      check("rr_gap_req", mem_req, 0);
      check("rr_gap_rdy", {i_ready, d_ready}, 0);
    end
    i_req = 1'b0;
    d_req = 1'b0;

    // Watchdog timeout on a data read (TIMEOUT = 4)
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 64'h500;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("to_req_high", mem_req, 1);
      check("to_err_low",  mem_err, 0);
    end
    tick();
    d_req = 1'b0;
    check("to_req_drop", mem_req, 0);
    check("to_err_set",  mem_err, 1);
    check("to_d_ready",  d_ready, 1);
    check("to_i_ready",  i_ready, 0);
    check("to_d_rdata",  d_rdata, 64'h1003);
    tick();
    check("to_ready_1cyc", d_ready, 0);
    check("to_err_sticky", mem_err, 1);
    i_req  = 1'b1;
    i_addr = 64'h600;
    tick();
    check("to_next_req",  mem_req,  1);
    check("to_next_addr", mem_addr, 64'h600);
    mem_ack   = 1'b1;
    mem_rdata = 64'hA5A5;
    tick();
    mem_ack = 1'b0;
    i_req   = 1'b0;
    check("to_next_ready", i_ready, 1);
    check("to_next_rdata", i_rdata, 64'hA5A5);
    check("to_err_still",  mem_err, 1);
    tick();

    // Reset asserted mid-transaction in BUSY_D
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 64'h700;
    d_wdata = 64'h77;
    tick();
    check("rb_mem_req", mem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rb_req_async", mem_req, 0);
    check("rb_err_clear", mem_err, 0);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    reset = 1'b0;
    check("rb_no_ready", d_ready, 0);
    tick();
    check("rb_idle_ready", d_ready, 0);
    check("rb_idle_req",   mem_req, 0);
    i_req  = 1'b1;
    i_addr = 64'h800;
    tick();
    check("rb_fetch_req",  mem_req,  1);
    check("rb_fetch_addr", mem_addr, 64'h800);
    mem_ack   = 1'b1;
    mem_rdata = 64'hBEEF;
    tick();
    mem_ack = 1'b0;
    i_req   = 1'b0;
    check("rb_fetch_ready", i_ready, 1);
    check("rb_fetch_rdata", i_rdata, 64'hBEEF);
    tick();

    // Stray ack in IDLE
    mem_ack   = 1'b1;
    mem_rdata = 64'hBAD;
    tick();
    mem_ack = 1'b0;
    check("si_rdy",     {i_ready, d_ready}, 0);
    check("si_req",     mem_req, 0);
    check("si_i_rdata", i_rdata, 64'hBEEF);
    check("si_d_rdata", d_rdata, 0);

    // Stray ack in RESP
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 64'h900;
    tick();
    check("sr_req", mem_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = 64'h99;
    tick();
    d_req     = 1'b0;
    mem_rdata = 64'hBAD;
    check("sr_d_ready", d_ready, 1);
    check("sr_d_rdata", d_rdata, 64'h99);
    tick();
    mem_ack = 1'b0;
    check("sr_rdy_after", {i_ready, d_ready}, 0);
    check("sr_d_hold",    d_rdata, 64'h99);
    check("sr_i_hold",    i_rdata, 64'hBEEF);
    check("sr_req_low",   mem_req, 0);
    tick();
    check("sr_idle_req",  mem_req, 0);
    check("sr_idle_rdy",  {i_ready, d_ready}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
